// File: rtl/moving_sum_accumulator.sv
// Boxcar moving sum of the last WINDOW accepted samples, fed by an external WINDOW-deep delay line.
// Optional rounded mean output o_mean is built only when MOVING_SUM_MEAN_EN is defined.
module moving_sum_accumulator #(
  parameter int WIDTH  = 10,
  parameter int WINDOW = 10,
  parameter bit SIGNED = 1'b0,
  localparam int SUM_W = WIDTH + $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             o_valid,
  output logic [SUM_W-1:0] o_sum,
  output logic             o_full,
  output logic             o_err
`ifdef MOVING_SUM_MEAN_EN
  ,
  output logic [WIDTH-1:0] o_mean
`endif
);

  localparam int               CNT_W   = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WINDOW);

  function automatic logic signed [SUM_W-1:0] ext(input logic [WIDTH-1:0] v);
    logic sx;
    sx = SIGNED & v[WIDTH-1];
    return {{(SUM_W - WIDTH){sx}}, v};
  endfunction

`ifdef MOVING_SUM_MEAN_EN
  localparam int                       MEAN_W   = SUM_W + 2;
  localparam bit                       IS_POW2  = ((WINDOW & (WINDOW - 1)) == 0);
  localparam int                       LOG2_W   = $clog2(WINDOW);
  localparam logic signed [MEAN_W-1:0] WIN_DIV  = MEAN_W'(WINDOW);
  localparam logic signed [MEAN_W-1:0] WIN_HALF = MEAN_W'(WINDOW / 2);

  // floor((s + WINDOW/2) / WINDOW): half-up, i.e. half toward +inf for signed sums
  function automatic logic [WIDTH-1:0] round_mean(input logic signed [SUM_W-1:0] s);
    logic signed [MEAN_W-1:0] t;
    logic signed [MEAN_W-1:0] q;
    t = {{2{SIGNED & s[SUM_W-1]}}, s};
    t = t + WIN_HALF;
    if (IS_POW2) begin
      q = t >>> LOG2_W;
    end else begin
      q = t / WIN_DIV;
      if ((t < 0) && ((q * WIN_DIV) != t)) q = q - MEAN_W'(1);
    end
    return q[WIDTH-1:0];
  endfunction
`endif

  logic signed [SUM_W-1:0] acc_p1;
  logic        [CNT_W-1:0] cnt_p1;
  logic                    vld_p1;
  logic                    full_p1;
  logic                    err_p1;

  logic signed [SUM_W-1:0] add_p0;
  logic signed [SUM_W-1:0] sub_p0;
  logic signed [SUM_W-1:0] acc_nxt_p0;
  logic        [CNT_W-1:0] cnt_nxt_p0;
  logic                    win_full_p0;
  logic                    align_err_p0;

  // Stage p0: combinational update from the current beat and the delayed sample
  always_comb begin
    add_p0       = ext(i_data);
    sub_p0       = d_valid ? ext(d_data) : '0;
    acc_nxt_p0   = acc_p1 + add_p0 - sub_p0;
    win_full_p0  = (cnt_p1 == WIN_CNT);
    cnt_nxt_p0   = win_full_p0 ? cnt_p1 : cnt_p1 + CNT_W'(1);
    // the delay line must present a valid sample exactly once the window is full
    align_err_p0 = i_valid ? (d_valid != win_full_p0) : d_valid;
  end

  // Stage p1: registered sum, fill state and sticky alignment error
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p1  <= '0;
      cnt_p1  <= '0;
      vld_p1  <= 1'b0;
      full_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      vld_p1 <= i_valid;
      if (align_err_p0) err_p1 <= 1'b1;
      if (i_valid) begin
        acc_p1  <= acc_nxt_p0;
        cnt_p1  <= cnt_nxt_p0;
        full_p1 <= (cnt_nxt_p0 == WIN_CNT);
      end
    end
  end

`ifdef MOVING_SUM_MEAN_EN
  logic [WIDTH-1:0] mean_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      mean_p1 <= '0;
    end else if (i_valid) begin
      mean_p1 <= round_mean(acc_nxt_p0);
    end
  end

  assign o_mean = mean_p1;
`endif

  assign o_valid = vld_p1;
  assign o_sum   = acc_p1;
  assign o_full  = full_p1;
  assign o_err   = err_p1;

endmodule

// File: tb/tb_moving_sum_accumulator.sv
// Self-checking bench: three accumulators (unsigned W=4, signed W=4, unsigned W=1) with a
// queue-based delay line and window-sum reference model.
module tb_moving_sum_accumulator;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic a_iv, a_dv, a_ov, a_full, a_err;
  logic [7:0] a_id, a_dd;
  logic [10:0] a_sum;
  logic b_iv, b_dv, b_ov, b_full, b_err;
  logic [7:0] b_id, b_dd;
  logic [10:0] b_sum;
  logic c_iv, c_dv, c_ov, c_full, c_err;
  logic [7:0] c_id, c_dd;
  logic [8:0] c_sum;
`ifdef MOVING_SUM_MEAN_EN
  logic [7:0] a_mean, b_mean, c_mean;
`endif

  moving_sum_accumulator #(.WIDTH(8), .WINDOW(4), .SIGNED(1'b0)) u_a (
    .clk(clk), .reset(reset), .i_valid(a_iv), .i_data(a_id), .d_valid(a_dv), .d_data(a_dd),
    .o_valid(a_ov), .o_sum(a_sum), .o_full(a_full), .o_err(a_err)
`ifdef MOVING_SUM_MEAN_EN
    , .o_mean(a_mean)
`endif
  );

  moving_sum_accumulator #(.WIDTH(8), .WINDOW(4), .SIGNED(1'b1)) u_b (
    .clk(clk), .reset(reset), .i_valid(b_iv), .i_data(b_id), .d_valid(b_dv), .d_data(b_dd),
    .o_valid(b_ov), .o_sum(b_sum), .o_full(b_full), .o_err(b_err)
`ifdef MOVING_SUM_MEAN_EN
    , .o_mean(b_mean)
`endif
  );

  moving_sum_accumulator #(.WIDTH(8), .WINDOW(1), .SIGNED(1'b0)) u_c (
    .clk(clk), .reset(reset), .i_valid(c_iv), .i_data(c_id), .d_valid(c_dv), .d_data(c_dd),
    .o_valid(c_ov), .o_sum(c_sum), .o_full(c_full), .o_err(c_err)
`ifdef MOVING_SUM_MEAN_EN
    , .o_mean(c_mean)
`endif
  );

  int checks = 0;
  int errors = 0;
  int hist_a[$];
  int hist_b[$];
  int hist_c[$];
  int off_a;
  bit ea;

  function automatic int msum(input int q[$], input int w);
    int s = 0;
    for (int i = 0; i < w && i < q.size(); i++) s += q[q.size() - 1 - i];
    return s;
  endfunction

  function automatic int mean_ref(input int s, input int w);
    int t;
    t = s + w / 2;
    if (t >= 0) return t / w;
    return -((-t + w - 1) / w);
  endfunction

  // One clock: drive at negedge, delay line model supplies d_*, sample at the next negedge.
  task automatic step(input bit va, input int xa, input bit fa,
                      input bit vb, input int xb, input bit vc, input int xc);
    int n;
    a_iv = va; a_id = 8'(xa);
    n = hist_a.size();
    if (va && n >= 4) begin a_dv = 1'b1; a_dd = 8'(hist_a[n - 4]); end
    else begin a_dv = 1'b0; a_dd = 8'($urandom); end
    if (fa) begin
      if (!(va && n >= 4)) begin
        ea = 1'b1;
        a_dd = 8'd5;
        if (va) off_a += 5;
      end
      a_dv = 1'b1;
    end
    b_iv = vb; b_id = 8'(xb);
    n = hist_b.size();
    if (vb && n >= 4) begin b_dv = 1'b1; b_dd = 8'(hist_b[n - 4]); end
    else begin b_dv = 1'b0; b_dd = 8'($urandom); end
    c_iv = vc; c_id = 8'(xc);
    n = hist_c.size();
    if (vc && n >= 1) begin c_dv = 1'b1; c_dd = 8'(hist_c[n - 1]); end
    else begin c_dv = 1'b0; c_dd = 8'($urandom); end
    @(posedge clk);
    if (va) hist_a.push_back(xa & 255);
    if (vb) hist_b.push_back(xb);
    if (vc) hist_c.push_back(xc & 255);
    @(negedge clk);
    a_iv = 1'b0; a_dv = 1'b0; b_iv = 1'b0; b_dv = 1'b0; c_iv = 1'b0; c_dv = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_iv = 1'b0; a_dv = 1'b0; b_iv = 1'b0; b_dv = 1'b0; c_iv = 1'b0; c_dv = 1'b0;
    a_id = '0; a_dd = '0; b_id = '0; b_dd = '0; c_id = '0; c_dd = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    hist_a.delete(); hist_b.delete(); hist_c.delete();
    off_a = 0; ea = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (a_ov !== 1'b0 || a_sum !== 11'd0 || a_full !== 1'b0 || a_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: valid=%b sum=%0d full=%b err=%b, required 0 0 0 0", a_ov, a_sum, a_full, a_err);
    end
    checks++;
    if (b_ov !== 1'b0 || b_sum !== 11'd0 || b_full !== 1'b0 || b_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: valid=%b sum=%0d full=%b err=%b, required 0 0 0 0", b_ov, b_sum, b_full, b_err);
    end
    checks++;
    if (c_ov !== 1'b0 || c_sum !== 9'd0 || c_full !== 1'b0 || c_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_c: valid=%b sum=%0d full=%b err=%b, required 0 0 0 0", c_ov, c_sum, c_full, c_err);
    end
  endtask

  task automatic test_back_to_back();
    int e[6] = '{1, 3, 6, 10, 14, 18};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, i + 1, 1'b0, 1'b0, 0, 1'b0, 0);
      checks++;
      if (a_ov !== 1'b1 || int'(a_sum) !== e[i] || a_full !== (i >= 3) || a_err !== 1'b0) begin
        errors++;
        $display("FAIL b2b[%0d]: valid=%b sum=%0d full=%b err=%b, required 1 %0d %b 0",
                 i, a_ov, a_sum, a_full, a_err, e[i], (i >= 3));
      end
    end
    step(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    checks++;
    if (a_ov !== 1'b0 || int'(a_sum) !== 18 || a_full !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: valid=%b sum=%0d full=%b, required 0 18 1", a_ov, a_sum, a_full);
    end
  endtask

  task automatic test_gaps();
    int e[5] = '{10, 30, 60, 100, 140};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, (i + 1) * 10, 1'b0, 1'b0, 0, 1'b0, 0);
      checks++;
      if (a_ov !== 1'b1 || int'(a_sum) !== e[i] || a_full !== (i >= 3)) begin
        errors++;
        $display("FAIL gap_beat[%0d]: valid=%b sum=%0d full=%b, required 1 %0d %b",
                 i, a_ov, a_sum, a_full, e[i], (i >= 3));
      end
      for (int g = 0; g < 3; g++) begin
        step(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
        checks++;
        if (a_ov !== 1'b0 || int'(a_sum) !== e[i]) begin
          errors++;
          $display("FAIL gap_hold[%0d.%0d]: valid=%b sum=%0d, required 0 %0d", i, g, a_ov, a_sum, e[i]);
        end
      end
    end
  endtask

  task automatic test_signed();
    int v[5] = '{-128, -128, -128, -128, 127};
    int e[5] = '{-128, -256, -384, -512, -257};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 0, 1'b0, 1'b1, v[i], 1'b0, 0);
      checks++;
      if (b_ov !== 1'b1 || int'($signed(b_sum)) !== e[i] || b_err !== 1'b0 || b_full !== (i >= 3)) begin
        errors++;
        $display("FAIL signed[%0d]: valid=%b sum=%0d err=%b full=%b, required 1 %0d 0 %b",
                 i, b_ov, $signed(b_sum), b_err, b_full, e[i], (i >= 3));
      end
    end
  endtask

  task automatic test_align_err();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, i + 3, (i == 1), 1'b0, 0, 1'b0, 0);
      checks++;
      if (a_err !== ea || int'(a_sum) !== msum(hist_a, 4) - off_a) begin
        errors++;
        $display("FAIL align[%0d]: err=%b sum=%0d, required %b %0d", i, a_err, a_sum, ea, msum(hist_a, 4) - off_a);
      end
    end
    do_reset();
    checks++;
    if (a_err !== 1'b0 || a_sum !== 11'd0) begin
      errors++;
      $display("FAIL align_reset: err=%b sum=%0d, required 0 0", a_err, a_sum);
    end
    step(1'b1, 9, 1'b0, 1'b0, 0, 1'b0, 0);
    step(1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 0);
    checks++;
    if (a_err !== 1'b1 || a_ov !== 1'b0 || int'(a_sum) !== 9) begin
      errors++;
      $display("FAIL align_idle: err=%b valid=%b sum=%0d, required 1 0 9", a_err, a_ov, a_sum);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, int'($urandom_range(0, 255)), 1'b0, 1'b0, 0, 1'b0, 0);
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 7, 1'b0, 1'b0, 0, 1'b0, 0);
      checks++;
      if (a_ov !== 1'b1 || int'(a_sum) !== 7 * (i + 1) || a_full !== 1'b0 || a_err !== 1'b0) begin
        errors++;
        $display("FAIL midreset[%0d]: valid=%b sum=%0d full=%b err=%b, required 1 %0d 0 0",
                 i, a_ov, a_sum, a_full, a_err, 7 * (i + 1));
      end
    end
  endtask

  task automatic test_random();
    bit va, vb, vc;
    int xa, xb, xc;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      va = ($urandom_range(0, 3) != 0); xa = int'($urandom_range(0, 255));
      vb = ($urandom_range(0, 3) != 0); xb = int'($urandom_range(0, 255)) - 128;
      vc = ($urandom_range(0, 2) != 0); xc = int'($urandom_range(0, 255));
      step(va, xa, 1'b0, vb, xb, vc, xc);
      checks++;
      if (a_ov !== va || int'(a_sum) !== msum(hist_a, 4) || a_full !== (hist_a.size() >= 4) || a_err !== 1'b0) begin
        errors++;
        $display("FAIL rand_a[%0d]: valid=%b sum=%0d full=%b err=%b, required %b %0d %b 0",
                 i, a_ov, a_sum, a_full, a_err, va, msum(hist_a, 4), (hist_a.size() >= 4));
      end
      checks++;
      if (b_ov !== vb || int'($signed(b_sum)) !== msum(hist_b, 4) || b_full !== (hist_b.size() >= 4) || b_err !== 1'b0) begin
        errors++;
        $display("FAIL rand_b[%0d]: valid=%b sum=%0d full=%b err=%b, required %b %0d %b 0",
                 i, b_ov, $signed(b_sum), b_full, b_err, vb, msum(hist_b, 4), (hist_b.size() >= 4));
      end
      checks++;
      if (c_ov !== vc || int'(c_sum) !== msum(hist_c, 1) || c_full !== (hist_c.size() >= 1) || c_err !== 1'b0) begin
        errors++;
        $display("FAIL rand_c[%0d]: valid=%b sum=%0d full=%b err=%b, required %b %0d %b 0",
                 i, c_ov, c_sum, c_full, c_err, vc, msum(hist_c, 1), (hist_c.size() >= 1));
      end
`ifdef MOVING_SUM_MEAN_EN
      checks++;
      if (int'(a_mean) !== mean_ref(msum(hist_a, 4), 4) || int'($signed(b_mean)) !== mean_ref(msum(hist_b, 4), 4) ||
          int'(c_mean) !== msum(hist_c, 1)) begin
        errors++;
        $display("FAIL rand_mean[%0d]: a=%0d b=%0d c=%0d, required %0d %0d %0d", i, a_mean, $signed(b_mean), c_mean,
                 mean_ref(msum(hist_a, 4), 4), mean_ref(msum(hist_b, 4), 4), msum(hist_c, 1));
      end
`endif
    end
  endtask

`ifdef MOVING_SUM_MEAN_EN
  task automatic test_mean();
    int va[6] = '{1, 2, 3, 4, 4, 4};
    int vb[6] = '{-2, -1, -3, 5, -6, 2};
    do_reset();
    checks++;
    if (a_mean !== 8'd0 || b_mean !== 8'd0) begin
      errors++;
      $display("FAIL mean_reset: a=%0d b=%0d, required 0 0", a_mean, b_mean);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, va[i], 1'b0, 1'b1, vb[i], 1'b0, 0);
      checks++;
      if (int'(a_mean) !== mean_ref(msum(hist_a, 4), 4) || int'($signed(b_mean)) !== mean_ref(msum(hist_b, 4), 4)) begin
        errors++;
        $display("FAIL mean[%0d]: a=%0d b=%0d, required %0d %0d", i, a_mean, $signed(b_mean),
                 mean_ref(msum(hist_a, 4), 4), mean_ref(msum(hist_b, 4), 4));
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_signed();
    test_align_err();
    test_reset_midstream();
    test_random();
`ifdef MOVING_SUM_MEAN_EN
    test_mean();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
